mem_port_arbiter: RTL and testbench

//  Shares one single-port data memory between the instruction-fetch port (IF) and the

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin front end that lets the IF and LS ports share one single-port memory,
// with one transaction outstanding at a time and a fixed memory read latency.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT=%0d is outside 1..7", MEM_LAT);
        end
    endgenerate

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {PORT_IF, PORT_LS} port_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    port_t             last_grant_q, last_grant_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic              cur_we_q, cur_we_d;
    logic              if_gnt_q, if_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              ls_gnt_q, ls_gnt_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              ls_wins;

    // On a tie the port that did not win last time gets the memory.
    assign ls_wins = ls_req && (!if_req || last_grant_q == PORT_IF);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_cnt_d    = lat_cnt_q;
        cur_we_d     = cur_we_q;
        busy_d       = busy_q;
        if_gnt_d     = 1'b0;
        ls_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        ls_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_LOAD;
                    busy_d    = 1'b1;
                    mem_en_d  = 1'b1;
                    if (ls_wins) begin
                        ls_gnt_d     = 1'b1;
                        last_grant_d = PORT_LS;
                        cur_we_d     = ls_we;
                        mem_we_d     = ls_we;
                        mem_addr_d   = ls_addr;
                        mem_wdata_d  = ls_wdata;
                    end else begin
                        if_gnt_d     = 1'b1;
                        last_grant_d = PORT_IF;
                        cur_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                    end
                end
            end
            WAIT: begin
                // mem_rdata is sampled on the edge that ends the last wait cycle.
                if (lat_cnt_q == 3'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (last_grant_q == PORT_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = cur_we_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_IF;
            lat_cnt_q    <= 3'd0;
            cur_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            if_gnt_q     <= 1'b0;
            ls_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_cnt_q    <= lat_cnt_d;
            cur_we_q     <= cur_we_d;
            busy_q       <= busy_d;
            if_gnt_q     <= if_gnt_d;
            ls_gnt_q     <= ls_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_gnt    = ls_gnt_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors on a MEM_LAT=2 instance, plus random
// traffic on MEM_LAT=1 and MEM_LAT=7 instances compared against a transaction model.
module tb_mem_port_arbiter;

    localparam logic [63:0] POISON = 64'hBADB_ADBA_DBAD_0000;

    function automatic logic [63:0] mem_init(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit rand_on = 1'b0;
    logic rand_reset = 1'b1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed instance, MEM_LAT = 2.
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr;
    logic [63:0] if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [7:0]  ls_addr;
    logic [63:0] ls_wdata, ls_rdata;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [63:0] tbmem [256];
    int          age = 15;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(64), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = mem_init(i);
        tbmem[8'h10] = 64'hDEAD;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) tbmem[mem_addr] <= mem_wdata;
        age <= mem_en ? 1 : ((age < 15) ? age + 1 : age);
    end

    // Read data is only valid in the one cycle the arbiter should sample it.
    assign mem_rdata = (!mem_en && age == 1) ? tbmem[mem_addr] : POISON;

    typedef struct {
        logic        if_req;
        logic [7:0]  if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [7:0]  ls_addr;
        logic [63:0] ls_wdata;
        logic        exp_ls;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        if_req = v.if_req; if_addr = v.if_addr;
        ls_req = v.ls_req; ls_we = v.ls_we; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata;
    endtask

    function automatic logic any_output();
        return |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, busy};
    endfunction

    // Random-traffic instances with their own memories and transaction-level model.
    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int L = (g == 0) ? 1 : 7;
        logic        r_if_req, r_if_gnt, r_if_rvalid;
        logic [7:0]  r_if_addr;
        logic [63:0] r_if_rdata;
        logic        r_ls_req, r_ls_we, r_ls_gnt, r_ls_rvalid;
        logic [7:0]  r_ls_addr;
        logic [63:0] r_ls_wdata, r_ls_rdata;
        logic        r_mem_en, r_mem_we, r_busy;
        logic [7:0]  r_mem_addr;
        logic [63:0] r_mem_wdata, r_mem_rdata;
        logic [63:0] rmem [256];
        logic [63:0] refmem [256];
        int          r_age = 15;
        int          cyc = 0;
        int          rv_cyc = -1;
        int          rv_port = 0;
        int          exp_gnt = 0;
        logic [63:0] rv_data;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [63:0] exp_wdata;
        bit          last_ls = 1'b0;
        bit          pick_ls;

        mem_port_arbiter #(.ADDR_W(8), .DATA_W(64), .MEM_LAT(L)) dut_r (
            .clk(clk), .reset(rand_reset),
            .if_req(r_if_req), .if_addr(r_if_addr), .if_gnt(r_if_gnt), .if_rvalid(r_if_rvalid), .if_rdata(r_if_rdata),
            .ls_req(r_ls_req), .ls_we(r_ls_we), .ls_addr(r_ls_addr), .ls_wdata(r_ls_wdata),
            .ls_gnt(r_ls_gnt), .ls_rvalid(r_ls_rvalid), .ls_rdata(r_ls_rdata),
            .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
            .mem_rdata(r_mem_rdata), .busy(r_busy)
        );

        initial begin
            for (int i = 0; i < 256; i++) begin
                rmem[i]   = mem_init(i);
                refmem[i] = mem_init(i);
            end
            r_if_req = 1'b0; r_if_addr = '0;
            r_ls_req = 1'b0; r_ls_we = 1'b0; r_ls_addr = '0; r_ls_wdata = '0;
        end

        always @(posedge clk) begin
            if (r_mem_en && r_mem_we) rmem[r_mem_addr] <= r_mem_wdata;
            r_age <= r_mem_en ? 1 : ((r_age < 15) ? r_age + 1 : r_age);
        end

        assign r_mem_rdata = ((r_mem_en && L == 1) || (!r_mem_en && r_age == L - 1)) ?
                             rmem[r_mem_addr] : POISON;

        always @(negedge clk) begin
            if (rand_on) begin
                cyc++;
                check_output("rnd_gnt", {r_if_gnt, r_ls_gnt}, {exp_gnt == 1, exp_gnt == 2});
                check_output("rnd_mem_en", r_mem_en, exp_gnt != 0);
                if (exp_gnt != 0) begin
                    check_output("rnd_mem_we", r_mem_we, exp_we);
                    check_output("rnd_mem_addr", r_mem_addr, exp_addr);
                    if (exp_we) check_output("rnd_mem_wdata", r_mem_wdata, exp_wdata);
                end
                check_output("rnd_rvalid", {r_if_rvalid, r_ls_rvalid},
                             {cyc == rv_cyc && rv_port == 1, cyc == rv_cyc && rv_port == 2});
                if (cyc == rv_cyc)
                    check_output("rnd_rdata", (rv_port == 1) ? r_if_rdata : r_ls_rdata, rv_data);
                check_output("rnd_busy", r_busy, rv_cyc > cyc);

                if (exp_gnt == 1) r_if_req = 1'b0;
                if (exp_gnt == 2) r_ls_req = 1'b0;
                if (!r_if_req && $urandom_range(0, 1) == 1) begin
                    r_if_req  = 1'b1;
                    r_if_addr = 8'($urandom_range(0, 15));
                end
                if (!r_ls_req && $urandom_range(0, 1) == 1) begin
                    r_ls_req   = 1'b1;
                    r_ls_we    = 1'($urandom_range(0, 1));
                    r_ls_addr  = 8'($urandom_range(0, 15));
                    r_ls_wdata = {$urandom, $urandom};
                end

                exp_gnt = 0;
                if (cyc >= rv_cyc && (r_if_req || r_ls_req)) begin
                    pick_ls   = r_ls_req && (!r_if_req || !last_ls);
                    last_ls   = pick_ls;
                    exp_gnt   = pick_ls ? 2 : 1;
                    exp_we    = pick_ls && r_ls_we;
                    exp_addr  = pick_ls ? r_ls_addr : r_if_addr;
                    exp_wdata = r_ls_wdata;
                    rv_cyc    = cyc + 1 + L;
                    rv_port   = exp_gnt;
                    rv_data   = exp_we ? 64'h0 : refmem[exp_addr];
                    if (exp_we) refmem[exp_addr] = exp_wdata;
                end
            end
        end
    end

    initial begin
        logic [1:0] exp_pair;

        vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 8'h10, 64'hDEAD};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 64'h1234, 1'b1, 1'b1, 8'h05, 64'h0};
        vecs[2] = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h05, 64'h0,    1'b0, 1'b0, 8'h20, mem_init(8'h20)};
        vecs[3] = '{1'b1, 8'h21, 1'b1, 1'b0, 8'h05, 64'h0,    1'b1, 1'b0, 8'h05, 64'h1234};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 64'h0,    1'b1, 1'b0, 8'h30, mem_init(8'h30)};
        vecs[5] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h40, 64'hCAFE, 1'b0, 1'b0, 8'h11, mem_init(8'h11)};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 64'h0,    1'b1, 1'b0, 8'h40, mem_init(8'h40)};
        vecs[7] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 8'h05, 64'h1234};

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rand_reset = 1'b0;
        rand_on = 1'b1;
        check_output("reset_outputs", any_output(), 1'b0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output("vec_gnt", {if_gnt, ls_gnt}, vecs[i].exp_ls ? 2'b01 : 2'b10);
            check_output("vec_mem_en", mem_en, 1'b1);
            check_output("vec_mem_we", mem_we, vecs[i].exp_we);
            check_output("vec_mem_addr", mem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_we) check_output("vec_mem_wdata", mem_wdata, vecs[i].ls_wdata);
            if_req = 1'b0; ls_req = 1'b0;
            @(negedge clk);
            check_output("vec_early_rvalid", {if_rvalid, ls_rvalid, mem_en}, 3'b000);
            check_output("vec_busy", busy, 1'b1);
            @(negedge clk);
            check_output("vec_rvalid", {if_rvalid, ls_rvalid}, vecs[i].exp_ls ? 2'b01 : 2'b10);
            check_output("vec_rdata", vecs[i].exp_ls ? ls_rdata : if_rdata, vecs[i].exp_rdata);
            check_output("vec_busy_done", busy, 1'b0);
        end

        // Both ports held requesting: LS, IF, LS with one idle-sample cycle between.
        apply_reset();
        if_req = 1'b1; if_addr = 8'h01; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h02;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_pair = (k == 4) ? 2'b10 : ((k == 1 || k == 7) ? 2'b01 : 2'b00);
            check_output("rr_gnt", {if_gnt, ls_gnt}, exp_pair);
            check_output("rr_busy", busy, (k == 3 || k == 6) ? 1'b0 : 1'b1);
        end

        // LS request arriving during an IF transaction waits for IDLE.
        apply_reset();
        if_req = 1'b1; if_addr = 8'h03; ls_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_pair = (k == 1) ? 2'b10 : ((k == 4) ? 2'b01 : 2'b00);
            check_output("late_gnt", {if_gnt, ls_gnt}, exp_pair);
            exp_pair = (k == 3) ? 2'b10 : ((k == 6) ? 2'b01 : 2'b00);
            check_output("late_rvalid", {if_rvalid, ls_rvalid}, exp_pair);
            check_output("late_busy", busy, (k == 1 || k == 2 || k == 4 || k == 5) ? 1'b1 : 1'b0);
            if (k == 3) check_output("late_if_rdata", if_rdata, mem_init(8'h03));
            if (k == 6) check_output("late_ls_rdata", ls_rdata, 64'h1234);
            if (k == 1) begin
                if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h05;
            end
            if (k == 4) ls_req = 1'b0;
        end

        // Reset right after a grant drops the transaction and re-arms the tie toward LS.
        for (int p = 0; p < 2; p++) begin
            apply_reset();
            if_req = (p == 0); if_addr = 8'h07;
            ls_req = (p == 1); ls_we = 1'b0; ls_addr = 8'h08;
            @(negedge clk);
            check_output("mid_gnt", {if_gnt, ls_gnt}, (p == 0) ? 2'b10 : 2'b01);
            if_req = 1'b0; ls_req = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_output("mid_reset_outputs", any_output(), 1'b0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_output("mid_no_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
            end
            if_req = 1'b1; ls_req = 1'b1;
            @(negedge clk);
            check_output("mid_tie_gnt", {if_gnt, ls_gnt}, 2'b01);
            if_req = 1'b0; ls_req = 1'b0;
        end

        repeat (3000) @(negedge clk);
        rand_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
